// File: rtl/matrix_mult_seq_if.sv
// Start/busy/done handshake and matrix bus for matrix_mult_seq.
// master drives operands and start; slave is the multiplier.
interface matrix_mult_seq_if #(
    parameter int MAX_DIM = 5,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 2
);
    localparam int MW = MAX_DIM * MAX_DIM * DATA_W;

    logic              start;
    logic [SIZE_W-1:0] matrix_size;
    logic [MW-1:0]     matrix_a;
    logic [MW-1:0]     matrix_b;
    logic [MW-1:0]     result_out;
    logic              overflow_flag;
    logic              busy;
    logic              done;

    modport master (
        output start, matrix_size, matrix_a, matrix_b,
        input  result_out, overflow_flag, busy, done
    );

    modport slave (
        input  start, matrix_size, matrix_a, matrix_b,
        output result_out, overflow_flag, busy, done
    );
endinterface

// File: rtl/matrix_mult_seq.sv
// Sequential signed matrix multiplier, one MAC per clock.
// Define MATMUL_SAT_EN to clamp out-of-range elements instead of wrapping.
module matrix_mult_seq #(
    parameter int MAX_DIM = 5,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    matrix_mult_seq_if.slave bus
);
    localparam int MW    = MAX_DIM * MAX_DIM * DATA_W;
    localparam int CNT_W = $clog2(MAX_DIM);
    localparam int IDX_W = $clog2(MAX_DIM * MAX_DIM);
    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = PW + $clog2(MAX_DIM);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t                  state_q, state_d;
    logic [MW-1:0]           a_q, a_d, b_q, b_d;
    logic [MW-1:0]           res_q, res_d;
    logic [CNT_W-1:0]        nm1_q, nm1_d;
    logic [CNT_W-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_nx;
    logic                    ovf_q, ovf_d;

    logic [IDX_W-1:0]         n_w, a_idx, b_idx, r_idx;
    logic signed [DATA_W-1:0] a_el, b_el;
    logic signed [PW-1:0]     prod;
    logic [ACC_W-DATA_W:0]    hi;
    logic                     out_rng;
    logic [DATA_W-1:0]        el;
    logic [31:0]              n_req;

    assign n_w   = IDX_W'(nm1_q) + IDX_W'(1);
    assign a_idx = IDX_W'(i_q) * n_w + IDX_W'(k_q);
    assign b_idx = IDX_W'(k_q) * n_w + IDX_W'(j_q);
    assign r_idx = IDX_W'(i_q) * IDX_W'(MAX_DIM) + IDX_W'(j_q);

    assign a_el   = a_q[a_idx*DATA_W +: DATA_W];
    assign b_el   = b_q[b_idx*DATA_W +: DATA_W];
    assign prod   = a_el * b_el;
    assign acc_nx = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};

    // In range iff every bit from the element sign bit upward agrees.
    assign hi      = acc_nx[ACC_W-1:DATA_W-1];
    assign out_rng = !((&hi) || !(|hi));

`ifdef MATMUL_SAT_EN
    assign el = !out_rng        ? acc_nx[DATA_W-1:0] :
                acc_nx[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                  {1'b0, {(DATA_W-1){1'b1}}};
`else
    assign el = acc_nx[DATA_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        nm1_d   = nm1_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        n_req   = 32'(bus.matrix_size) + 32'd2;
        if (n_req > 32'(MAX_DIM)) n_req = 32'(MAX_DIM);
        unique case (state_q)
            IDLE: if (bus.start) state_d = LOAD;
            LOAD: begin
                a_d     = bus.matrix_a;
                b_d     = bus.matrix_b;
                nm1_d   = CNT_W'(n_req - 32'd1);
                res_d   = '0;
                ovf_d   = 1'b0;
                acc_d   = '0;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                state_d = CALC;
            end
            CALC: begin
                if (k_q == nm1_q) begin
                    res_d[r_idx*DATA_W +: DATA_W] = el;
                    ovf_d = ovf_q | out_rng;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == nm1_q) begin
                        j_d = '0;
                        if (i_q == nm1_q) state_d = DONE;
                        else i_d = i_q + CNT_W'(1);
                    end else begin
                        j_d = j_q + CNT_W'(1);
                    end
                end else begin
                    acc_d = acc_nx;
                    k_d   = k_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            nm1_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            nm1_q   <= nm1_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.result_out    = res_q;
    assign bus.overflow_flag = ovf_q;
    assign bus.busy          = (state_q == LOAD) || (state_q == CALC);
    assign bus.done          = (state_q == DONE);
endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq: timeline model plus
// arithmetic reference model of C = A x B.
module tb_matrix_mult_seq;
    localparam int MD = 5;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int RW = MD * MD * DW;
`ifdef MATMUL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    matrix_mult_seq_if #(.MAX_DIM(MD), .DATA_W(DW), .SIZE_W(SW)) bus();

    matrix_mult_seq #(.MAX_DIM(MD), .DATA_W(DW), .SIZE_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          cur_n = 2;
    bit          active = 1'b0;
    bit          armed = 1'b0;
    logic [RW-1:0] cur_res = '0;
    logic [RW-1:0] new_res = '0;
    bit          cur_ovf = 1'b0;
    bit          new_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer sums, then wrap or clamp per element.
    function automatic void model(input int n, input int a[25], input int b[25],
                                  output logic [RW-1:0] r, output bit o);
        int s;
        logic [DW-1:0] el;
        r = '0;
        o = 1'b0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += a[i*n+k] * b[k*n+j];
                if (s > 127 || s < -128) begin
                    o = 1'b1;
                    if (SAT) s = (s > 0) ? 127 : -128;
                end
                el = DW'(s);
                r[(i*MD+j)*DW +: DW] = el;
            end
    endfunction

    always @(negedge clk) begin : cmp
        int e;
        if (armed) begin
            e = cyc - t0;
            if (!active) begin
                chk("idle_busy", bus.busy, '0);
                chk("idle_done", bus.done, '0);
                chk("held_res", bus.result_out, cur_res);
                chk("held_ovf", bus.overflow_flag, cur_ovf);
            end else if (e == 0) begin
                chk("load_busy", bus.busy, 1);
                chk("load_done", bus.done, '0);
                chk("load_res_held", bus.result_out, cur_res);
                chk("load_ovf_held", bus.overflow_flag, cur_ovf);
            end else if (e <= cur_n * cur_n * cur_n) begin
                chk("calc_busy", bus.busy, 1);
                chk("calc_done", bus.done, '0);
                if (e == 1) chk("calc_res_clr", bus.result_out, '0);
                if (!new_ovf) chk("calc_ovf_clr", bus.overflow_flag, '0);
            end else begin
                chk("done_pulse", bus.done, 1);
                chk("done_busy", bus.busy, '0);
                chk("done_res", bus.result_out, new_res);
                chk("done_ovf", bus.overflow_flag, new_ovf);
                cur_res = new_res;
                cur_ovf = new_ovf;
                active  = 1'b0;
            end
        end
    end

    task automatic launch(input int code, input int a[25], input int b[25]);
        int n;
        n = code + 2;
        if (n > MD) n = MD;
        @(negedge clk);
        #1;
        bus.matrix_size = SW'(code);
        bus.matrix_a = '0;
        bus.matrix_b = '0;
        for (int x = 0; x < n * n; x++) begin
            bus.matrix_a[x*DW +: DW] = DW'(a[x]);
            bus.matrix_b[x*DW +: DW] = DW'(b[x]);
        end
        model(n, a, b, new_res, new_ovf);
        cur_n = n;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        active = 1'b1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (active && c < 400) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (active) begin
            errors++;
            $display("FAIL timeout: no done after %0d cycles, want done", c);
            active = 1'b0;
        end
    endtask

    task automatic fill(output int m[25], input int v);
        for (int x = 0; x < 25; x++) m[x] = v;
    endtask

    int a[25], b[25];

    initial begin
        bus.start = 1'b0;
        bus.matrix_size = '0;
        bus.matrix_a = '0;
        bus.matrix_b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        armed = 1'b1;

        // n=2 basic product
        fill(a, 0);
        fill(b, 0);
        a[0] = 1; a[1] = 2; a[2] = 3; a[3] = 4;
        b[0] = 5; b[1] = 6; b[2] = 7; b[3] = 8;
        launch(0, a, b);
        wait_done();
        chk("lit_c00", bus.result_out[0*DW +: DW], 19);
        chk("lit_c01", bus.result_out[1*DW +: DW], 22);
        chk("lit_c10", bus.result_out[5*DW +: DW], 43);
        chk("lit_c11", bus.result_out[6*DW +: DW], 50);
        chk("lit_model_c11", cur_res[6*DW +: DW], 50);
        chk("lit_ovf0", bus.overflow_flag, '0);

        // n=3, all 10: overflow; start held during DONE must be ignored
        fill(a, 10);
        fill(b, 10);
        launch(1, a, b);
        while (active && (cyc - t0) < cur_n * cur_n * cur_n + 1) @(negedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();
        chk("lit_c3", bus.result_out[0*DW +: DW], SAT ? 127 : 44);
        chk("lit_c3_mid", bus.result_out[12*DW +: DW], SAT ? 127 : 44);
        chk("lit_model_c3", cur_res[12*DW +: DW], SAT ? 127 : 44);
        chk("lit_ovf1", bus.overflow_flag, 1);

        // back-to-back: non-overflow run clears the sticky flag at LOAD
        fill(a, 0);
        fill(b, 0);
        a[0] = 1; a[1] = 2; a[2] = 3; a[3] = 4;
        b[0] = 5; b[1] = 6; b[2] = 7; b[3] = 8;
        launch(0, a, b);
        wait_done();
        chk("b2b_ovf", bus.overflow_flag, '0);
        chk("b2b_c10", bus.result_out[5*DW +: DW], 43);

        // n=5, all -128
        fill(a, -128);
        fill(b, -128);
        launch(3, a, b);
        wait_done();
        chk("lit_c5", bus.result_out[24*DW +: DW], SAT ? 127 : 0);
        chk("lit_model_c5", cur_res[0 +: DW], SAT ? 127 : 0);
        chk("lit_ovf5", bus.overflow_flag, 1);

        // n=4 identity x B, with input churn during CALC
        fill(a, 0);
        fill(b, 0);
        for (int x = 0; x < 16; x++) b[x] = x - 8;
        for (int r = 0; r < 4; r++) a[r*4+r] = 1;
        launch(2, a, b);
        @(posedge clk);
        #1;
        repeat (20) begin
            @(negedge clk);
            bus.start = ~bus.start;
            for (int w = 0; w < MD * MD; w++)
                bus.matrix_a[w*DW +: DW] = DW'($urandom);
        end
        bus.start = 1'b0;
        wait_done();
        chk("lit_id_c00", bus.result_out[0 +: DW], 8'hF8);
        chk("lit_id_c33", bus.result_out[18*DW +: DW], 8'h07);

        // reset mid-operation on an n=5 run
        fill(a, 10);
        fill(b, 10);
        launch(3, a, b);
        while ((cyc - t0) < 39) @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        active = 1'b0;
        cur_res = '0;
        cur_ovf = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy, '0);
        chk("rst_res", bus.result_out, '0);
        chk("rst_ovf", bus.overflow_flag, '0);

        // fresh run after reset, then a mixed-sign n=3 run
        launch(3, a, b);
        wait_done();
        chk("lit_post_rst", bus.result_out[0 +: DW], SAT ? 127 : 244);
        for (int x = 0; x < 25; x++) begin
            a[x] = $urandom_range(0, 30) - 15;
            b[x] = $urandom_range(0, 30) - 15;
        end
        launch(1, a, b);
        wait_done();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
